// File: rtl/integration_sequencer.sv
// -----------------------------------------------------------------------------
// integration_sequencer
//
// Controls integration windows for the correlator accumulator array. The
// correlator is held in clear, a programmed number of sample ticks is counted,
// the accumulator pipeline is allowed to settle, then the PAYLOAD_SIZE-bit
// pulses bus is snapshotted into a shadow register and drained LSB byte first
// over a valid/ready byte stream. In continuous mode the next integration runs
// while the previous frame drains; a snapshot that finds the drainer still
// busy is dropped and flagged in the sticky overrun output.
//
// Optional build macro: FRAME_HEADER_EN
//   defined   - every frame is prefixed by A5, 5A, frame_count[15:8],
//               frame_count[7:0] (post-increment count), N+4 bytes per frame.
//   undefined - payload bytes only, N = PAYLOAD_SIZE/8 bytes per frame.
//
// Ports:
//   pllclk       in   system clock
//   reset        in   synchronous, active-low reset
//   start        in   one-cycle request to begin integrating (IDLE only)
//   stop         in   abort integration / leave continuous mode
//   continuous   in   latched at start, 1 = repeat integrations
//   integ_len    in   ticks per integration, latched at start, 0 acts as 1
//   tick         in   sample strobe, counted only while integrating
//   pulses       in   correlator accumulator bus
//   corr_reset   out  active-high clear to the correlator
//   tx_data      out  stream byte
//   tx_valid     out  stream valid
//   tx_ready     in   stream ready
//   tx_last      out  final byte of a frame
//   busy         out  control FSM not idle, or a drain in progress
//   overrun      out  sticky, a frame was dropped
//   frame_count  out  frames captured, wraps at 16 bits
// -----------------------------------------------------------------------------
module integration_sequencer #(
  parameter int unsigned PAYLOAD_SIZE  = 48,
  parameter int unsigned LEN_WIDTH     = 24,
  parameter int unsigned CLEAR_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                    pllclk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  input  logic [LEN_WIDTH-1:0]    integ_len,
  input  logic                    tick,
  input  logic [PAYLOAD_SIZE-1:0] pulses,
  output logic                    corr_reset,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_last,
  output logic                    busy,
  output logic                    overrun,
  output logic [15:0]             frame_count
);

  localparam int unsigned NBYTES = PAYLOAD_SIZE / 8;
`ifdef FRAME_HEADER_EN
  localparam int unsigned HDR_BYTES = 4;
`else
  localparam int unsigned HDR_BYTES = 0;
`endif
  localparam int unsigned TOTAL_BYTES = NBYTES + HDR_BYTES;
  localparam int unsigned IDX_W  = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam int unsigned PH_MAX = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(TOTAL_BYTES - 1);
  localparam logic [PH_W-1:0]      CLEAR_END = PH_W'(CLEAR_CYCLES - 1);
  localparam logic [PH_W-1:0]      SETTLE_END = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO  = LEN_WIDTH'(0);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_INTEGRATE = 3'd2,
    S_SETTLE    = 3'd3,
    S_SNAPSHOT  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [LEN_WIDTH-1:0]    tick_cnt_q, tick_cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic                    cont_q, cont_d;
  logic                    overrun_q, overrun_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic [PAYLOAD_SIZE-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_last_q, tx_last_d;
  logic                    corr_reset_q, corr_reset_d;
  logic                    busy_q, busy_d;
  logic [IDX_W-1:0]        idx_next_s;

  // Payload byte k of a frame, least significant byte first.
  function automatic logic [7:0] payload_byte(input logic [IDX_W-1:0] k,
                                              input logic [PAYLOAD_SIZE-1:0] data);
    return data[{k, 3'b000} +: 8];
  endfunction

  // Stream byte at position idx, including the header when it is built in.
  // Header count bytes are only requested after the snapshot edge, so the
  // frame_count register already holds this frame's post-increment value.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [PAYLOAD_SIZE-1:0] data);
`ifdef FRAME_HEADER_EN
    logic [7:0] b;
    case (idx)
      IDX_W'(0): b = 8'hA5;
      IDX_W'(1): b = 8'h5A;
      IDX_W'(2): b = frame_count_q[15:8];
      IDX_W'(3): b = frame_count_q[7:0];
      default:   b = payload_byte(idx - IDX_W'(HDR_BYTES), data);
    endcase
    return b;
`else
    return payload_byte(idx, data);
`endif
  endfunction

  assign idx_next_s = idx_q + IDX_W'(1);

  // Next-state logic for the control FSM, the drainer and all registered outputs.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    tick_cnt_d    = tick_cnt_q;
    len_d         = len_q;
    cont_d        = cont_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    shadow_d      = shadow_q;
    idx_d         = idx_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    tx_last_d     = tx_last_q;

    // stop outside INTEGRATE only ends continuous mode; the window in flight completes.
    if (stop && (state_q != S_INTEGRATE)) begin
      cont_d = 1'b0;
    end else begin
      cont_d = cont_q;
    end

    // Drainer: advance on handshake, drop valid after the last byte.
    if (tx_valid_q && tx_ready) begin
      if (tx_last_q) begin
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        idx_d      = IDX_W'(0);
      end else begin
        idx_d     = idx_next_s;
        tx_data_d = frame_byte(idx_next_s, shadow_q);
        tx_last_d = (idx_next_s == LAST_IDX);
      end
    end else begin
      idx_d = idx_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = (integ_len == LEN_ZERO) ? LEN_ONE : integ_len;
          cont_d    = continuous;
          overrun_d = 1'b0;
          phase_d   = PH_W'(0);
          state_d   = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (phase_q == CLEAR_END) begin
          phase_d    = PH_W'(0);
          tick_cnt_d = LEN_ZERO;
          state_d    = S_INTEGRATE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_INTEGRATE: begin
        // stop wins over a simultaneous final tick
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + LEN_ONE;
          if ((tick_cnt_q + LEN_ONE) == len_q) begin
            phase_d = PH_W'(0);
            state_d = S_SETTLE;
          end else begin
            state_d = S_INTEGRATE;
          end
        end else begin
          state_d = S_INTEGRATE;
        end
      end
      S_SETTLE: begin
        if (phase_q == SETTLE_END) begin
          phase_d = PH_W'(0);
          state_d = S_SNAPSHOT;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_SNAPSHOT: begin
        // A drainer still holding valid (even on its final handshake) counts as busy,
        // which also guarantees the idle gap between frames.
        if (tx_valid_q) begin
          overrun_d = 1'b1;
        end else begin
          shadow_d      = pulses;
          frame_count_d = frame_count_q + 16'd1;
          idx_d         = IDX_W'(0);
          tx_valid_d    = 1'b1;
          tx_data_d     = frame_byte(IDX_W'(0), pulses);
          tx_last_d     = (LAST_IDX == IDX_W'(0));
        end
        if (cont_q && !stop) begin
          phase_d = PH_W'(0);
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    corr_reset_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
    busy_d       = (state_d != S_IDLE) || tx_valid_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge pllclk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_W'(0);
      tick_cnt_q    <= LEN_ZERO;
      len_q         <= LEN_ONE;
      cont_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
      shadow_q      <= {PAYLOAD_SIZE{1'b0}};
      idx_q         <= IDX_W'(0);
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'd0;
      tx_last_q     <= 1'b0;
      corr_reset_q  <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      tick_cnt_q    <= tick_cnt_d;
      len_q         <= len_d;
      cont_q        <= cont_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      shadow_q      <= shadow_d;
      idx_q         <= idx_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      tx_last_q     <= tx_last_d;
      corr_reset_q  <= corr_reset_d;
      busy_q        <= busy_d;
    end
  end

  assign corr_reset  = corr_reset_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_last     = tx_last_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_integration_sequencer.sv
// -----------------------------------------------------------------------------
// tb_integration_sequencer
//
// Directed bench for integration_sequencer: reset state, single shot with
// exact corr_reset / latency timing, backpressure, continuous mode with
// overrun, abort on the final tick, zero length, and reset during a drain.
// Expected frames are built from the programmed pulses value and the expected
// frame count (with header bytes when FRAME_HEADER_EN is defined).
// -----------------------------------------------------------------------------
module tb_integration_sequencer;

  logic        pllclk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [23:0] integ_len;
  logic        tick;
  logic [47:0] pulses;
  logic        corr_reset;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic        overrun;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;

  integration_sequencer dut (
    .pllclk      (pllclk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .integ_len   (integ_len),
    .tick        (tick),
    .pulses      (pulses),
    .corr_reset  (corr_reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .busy        (busy),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  always #5 pllclk = ~pllclk;

  task automatic step();
    @(posedge pllclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_shot(input logic [23:0] len, input logic cont);
    integ_len  = len;
    continuous = cont;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  function automatic logic [7:0] first_byte(input logic [47:0] pl);
`ifdef FRAME_HEADER_EN
    return 8'hA5;
`else
    return pl[7:0];
`endif
  endfunction

  // Receive one frame (waiting for it if needed), checking every byte while
  // valid is high; with bp set tx_ready alternates 0/1 each cycle.
  task automatic recv_frame(input string tag, input logic [47:0] pl,
                            input logic [15:0] fc, input bit bp);
    logic [7:0] exp_b [16];
    int n;
    int k;
    int cyc;
    n = 0;
`ifdef FRAME_HEADER_EN
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h5A;
    exp_b[2] = fc[15:8];
    exp_b[3] = fc[7:0];
    n = 4;
`endif
    for (int i = 0; i < 6; i++) begin
      exp_b[n] = pl[8*i +: 8];
      n++;
    end
    k   = 0;
    cyc = 0;
    while ((k < n) && (cyc < 300)) begin
      tx_ready = bp ? cyc[0] : 1'b1;
      if (tx_valid) begin
        chk($sformatf("%s_data%0d", tag, k), tx_data, exp_b[k]);
        chk($sformatf("%s_last%0d", tag, k), tx_last, (k == n - 1));
        if (tx_ready) k++;
      end
      step();
      cyc++;
    end
    chk({tag, "_bytes"}, k, n);
    chk({tag, "_gap"}, tx_valid, 1'b0);
    chk({tag, "_fcount"}, frame_count, fc);
    tx_ready = 1'b1;
  endtask

  initial begin
    int early;
    reset      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    integ_len  = 24'd0;
    tick       = 1'b0;
    pulses     = 48'h0;
    tx_ready   = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_corr_reset", corr_reset, 1'b1);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_last", tx_last, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_fcount", frame_count, 16'd0);
    reset = 1'b1;
    step();

    // Single shot, len 4, exact timing
    pulses = 48'h0605_0403_0201;
    start_shot(24'd4, 1'b0);
    chk("ss_clr0", corr_reset, 1'b1);
    chk("ss_busy", busy, 1'b1);
    step();
    chk("ss_clr1", corr_reset, 1'b1);
    step();
    chk("ss_integ", corr_reset, 1'b0);
    tick = 1'b1;
    repeat (4) step();
    tick = 1'b0;
    chk("ss_settle_cr", corr_reset, 1'b0);
    step();
    step();
    chk("ss_snap_valid", tx_valid, 1'b0);
    chk("ss_snap_cr", corr_reset, 1'b0);
    step();
    chk("ss_first_valid", tx_valid, 1'b1);
    chk("ss_idle_cr", corr_reset, 1'b1);
    recv_frame("ss", 48'h0605_0403_0201, 16'd1, 1'b0);
    chk("ss_busy_end", busy, 1'b0);
    chk("ss_overrun", overrun, 1'b0);

    // Backpressure
    pulses = 48'hA1B2_C3D4_E5F6;
    tick   = 1'b1;
    start_shot(24'd3, 1'b0);
    recv_frame("bp", 48'hA1B2_C3D4_E5F6, 16'd2, 1'b1);
    tick = 1'b0;

    // Continuous with overrun
    tx_ready = 1'b0;
    tick     = 1'b1;
    pulses   = 48'h1122_3344_5566;
    start_shot(24'd1, 1'b1);
    repeat (8) step();
    pulses = 48'hDEAD_BEEF_0000;
    repeat (12) step();
    chk("co_overrun", overrun, 1'b1);
    chk("co_fcount", frame_count, 16'd3);
    chk("co_valid", tx_valid, 1'b1);
    chk("co_held", tx_data, first_byte(48'h1122_3344_5566));
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (10) step();
    chk("co_stopped_cr", corr_reset, 1'b1);
    recv_frame("co", 48'h1122_3344_5566, 16'd3, 1'b0);
    repeat (5) step();
    chk("co_busy_end", busy, 1'b0);
    chk("co_fcount_end", frame_count, 16'd3);
    chk("co_overrun_sticky", overrun, 1'b1);
    tick = 1'b0;

    // Abort: stop coincident with the final tick
    start_shot(24'd3, 1'b0);
    chk("ab_overrun_clr", overrun, 1'b0);
    step();
    step();
    tick = 1'b1;
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    tick = 1'b0;
    chk("ab_idle_cr", corr_reset, 1'b1);
    chk("ab_busy", busy, 1'b0);
    early = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_valid) early++;
    end
    chk("ab_no_valid", early, 0);
    chk("ab_fcount", frame_count, 16'd3);

    // Zero length behaves as one tick
    pulses = 48'h0F0E_0D0C_0B0A;
    tick   = 1'b1;
    start_shot(24'd0, 1'b0);
    early = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tx_valid) early++;
    end
    chk("z_no_early", early, 0);
    step();
    chk("z_valid", tx_valid, 1'b1);
    recv_frame("z", 48'h0F0E_0D0C_0B0A, 16'd4, 1'b0);
    tick = 1'b0;

    // Reset during drain at byte 2
    pulses = 48'h7766_5544_3322;
    tick   = 1'b1;
    start_shot(24'd1, 1'b0);
    for (int i = 0; (i < 50) && !tx_valid; i++) step();
    chk("rd_valid", tx_valid, 1'b1);
    step();
    step();
    chk("rd_valid2", tx_valid, 1'b1);
    reset = 1'b0;
    step();
    chk("rd_tx_valid", tx_valid, 1'b0);
    chk("rd_corr_reset", corr_reset, 1'b1);
    chk("rd_fcount", frame_count, 16'd0);
    chk("rd_busy", busy, 1'b0);
    chk("rd_tx_data", tx_data, 8'h00);
    reset = 1'b1;
    tick  = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
